// File: rtl/mux_nto1_rr_if.sv
// Handshake bundle for mux_nto1_rr: N_CH valid/ready input channels and one registered output.
// MUX_PARITY_EN adds out_par (XOR of out_data) to the bundle.
interface mux_nto1_rr_if #(
  parameter int unsigned N_CH = 16,
  parameter int unsigned DW   = 8
);
  localparam int unsigned SELW = $clog2(N_CH);

  logic [N_CH*DW-1:0] in_data;
  logic [N_CH-1:0]    in_valid;
  logic [N_CH-1:0]    in_ready;
  logic               mode;
  logic [SELW-1:0]    sel;
  logic [DW-1:0]      out_data;
  logic [SELW-1:0]    out_ch;
  logic               out_valid;
  logic               out_ready;
`ifdef MUX_PARITY_EN
  logic               out_par;
`endif

  // master is the mux itself; slave is the sources/consumer side
  modport master (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_ch, out_valid
`ifdef MUX_PARITY_EN
    , output out_par
`endif
  );

  modport slave (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_ch, out_valid
`ifdef MUX_PARITY_EN
    , input out_par
`endif
  );
endinterface

// File: rtl/mux_nto1_rr.sv
// N-channel registered mux with fixed-select or round-robin grant and valid/ready on every side.
// Optional feature: define MUX_PARITY_EN to register out_par = ^out_data alongside the data.
module mux_nto1_rr #(
  parameter int unsigned N_CH = 16,
  parameter int unsigned DW   = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_nto1_rr_if.master  bus
);
  localparam int unsigned SELW = $clog2(N_CH);
  localparam int unsigned NPAD = 1 << SELW;

  logic [SELW-1:0] ptr_q;
  logic [DW-1:0]   data_q;
  logic [SELW-1:0] ch_q;
  logic            valid_q;
`ifdef MUX_PARITY_EN
  logic            par_q;
`endif

  logic [NPAD-1:0] valid_pad;
  logic [DW-1:0]   ch_data [NPAD];
  logic            sel_ok;
  logic            rr_hit;
  logic [SELW-1:0] rr_idx;
  int unsigned     cand;
  logic            grant_hit;
  logic [SELW-1:0] grant_idx;
  logic            accept;
  logic            xfer;
  logic [DW-1:0]   grant_data;

  // Pad to a power of two so any SELW-bit index stays in range; pad entries never request.
  always_comb begin
    valid_pad = '0;
    valid_pad[N_CH-1:0] = bus.in_valid;
    for (int unsigned i = 0; i < NPAD; i++) begin
      ch_data[i] = '0;
    end
    for (int unsigned i = 0; i < N_CH; i++) begin
      ch_data[i] = bus.in_data[i*DW +: DW];
    end
  end

  if (NPAD == N_CH) begin : g_sel_full
    assign sel_ok = 1'b1;
  end else begin : g_sel_range
    assign sel_ok = ({1'b0, bus.sel} < (SELW+1)'(N_CH));
  end

  // Round-robin: first requester strictly after ptr, wrapping modulo N_CH.
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    cand   = 0;
    for (int unsigned k = 1; k <= N_CH; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= N_CH) begin
        cand = cand - N_CH;
      end
      if (!rr_hit && valid_pad[cand[SELW-1:0]]) begin
        rr_hit = 1'b1;
        rr_idx = cand[SELW-1:0];
      end
    end
  end

  always_comb begin
    if (bus.mode) begin
      grant_hit = rr_hit;
      grant_idx = rr_idx;
    end else begin
      grant_hit = sel_ok && valid_pad[bus.sel];
      grant_idx = bus.sel;
    end
  end

  assign accept     = !valid_q || bus.out_ready;
  assign xfer       = accept && grant_hit;
  assign grant_data = ch_data[grant_idx];

  always_comb begin
    bus.in_ready = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      bus.in_ready[i] = xfer && (grant_idx == SELW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
      ptr_q   <= SELW'(N_CH - 1);
`ifdef MUX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else if (xfer) begin
      valid_q <= 1'b1;
      data_q  <= grant_data;
      ch_q    <= grant_idx;
      ptr_q   <= grant_idx;
`ifdef MUX_PARITY_EN
      par_q   <= ^grant_data;
`endif
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_ch    = ch_q;
`ifdef MUX_PARITY_EN
  assign bus.out_par   = par_q;
`endif

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Self-checking bench for mux_nto1_rr: a 16-channel and a 5-channel instance against a behavioural model.
// Build with MUX_PARITY_EN defined to also check out_par.
module tb_mux_nto1_rr;
  logic clk = 1'b0;
  logic rst16;
  logic rst5;
  always #5 clk = ~clk;

  mux_nto1_rr_if #(.N_CH(16), .DW(8)) b16 ();
  mux_nto1_rr_if #(.N_CH(5),  .DW(8)) b5 ();

  mux_nto1_rr #(.N_CH(16), .DW(8)) u16 (.clk(clk), .rst_n(rst16), .bus(b16));
  mux_nto1_rr #(.N_CH(5),  .DW(8)) u5  (.clk(clk), .rst_n(rst5),  .bus(b5));

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] d16 [16];
  logic [7:0] d5  [5];

  bit         init16 = 1'b0, init5 = 1'b0;
  bit         m16_v, m5_v;
  logic [7:0] m16_d, m5_d;
  int         m16_ch, m5_ch, m16_ptr, m5_ptr;
  bit         m16_par, m5_par;
  int         g16, g5;
  bit         acc16, acc5;
  logic [31:0] er16, er5;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Grant rule straight from the behaviour description: fixed index, or first requester after p modulo n.
  function automatic int model_grant(input logic [15:0] v, input int n, input logic m,
                                     input int s, input int p);
    int r;
    r = -1;
    if (!m) begin
      if (s < n) begin
        if (v[s]) r = s;
      end
    end else begin
      for (int k = n; k >= 1; k--) begin
        if (v[(p + k) % n]) r = (p + k) % n;
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (!rst16) begin
      init16 = 1'b1; m16_v = 1'b0; m16_d = 8'h00; m16_ch = 0; m16_ptr = 15; m16_par = 1'b0;
    end else if (init16) begin
      acc16 = !m16_v || b16.out_ready;
      g16 = model_grant(b16.in_valid, 16, b16.mode, int'(b16.sel), m16_ptr);
      if (acc16 && g16 >= 0) begin
        m16_v = 1'b1; m16_d = b16.in_data[g16*8 +: 8]; m16_ch = g16; m16_ptr = g16; m16_par = ^m16_d;
      end else if (b16.out_ready) begin
        m16_v = 1'b0;
      end
    end
    if (!rst5) begin
      init5 = 1'b1; m5_v = 1'b0; m5_d = 8'h00; m5_ch = 0; m5_ptr = 4; m5_par = 1'b0;
    end else if (init5) begin
      acc5 = !m5_v || b5.out_ready;
      g5 = model_grant({11'b0, b5.in_valid}, 5, b5.mode, int'(b5.sel), m5_ptr);
      if (acc5 && g5 >= 0) begin
        m5_v = 1'b1; m5_d = b5.in_data[g5*8 +: 8]; m5_ch = g5; m5_ptr = g5; m5_par = ^m5_d;
      end else if (b5.out_ready) begin
        m5_v = 1'b0;
      end
    end
  end

  // Per-cycle comparison on the falling edge, well away from input changes and register updates.
  always @(negedge clk) begin
    if (init16) begin
      g16 = model_grant(b16.in_valid, 16, b16.mode, int'(b16.sel), m16_ptr);
      er16 = ((!m16_v || b16.out_ready) && g16 >= 0) ? (32'd1 << g16) : 32'd0;
      chk("u16.out_valid", 32'(b16.out_valid), 32'(m16_v));
      chk("u16.out_data",  32'(b16.out_data),  32'(m16_d));
      chk("u16.out_ch",    32'(b16.out_ch),    32'(m16_ch));
      chk("u16.in_ready",  32'(b16.in_ready),  er16);
`ifdef MUX_PARITY_EN
      chk("u16.out_par",   32'(b16.out_par),   32'(m16_par));
`endif
    end
    if (init5) begin
      g5 = model_grant({11'b0, b5.in_valid}, 5, b5.mode, int'(b5.sel), m5_ptr);
      er5 = ((!m5_v || b5.out_ready) && g5 >= 0) ? (32'd1 << g5) : 32'd0;
      chk("u5.out_valid", 32'(b5.out_valid), 32'(m5_v));
      chk("u5.out_data",  32'(b5.out_data),  32'(m5_d));
      chk("u5.out_ch",    32'(b5.out_ch),    32'(m5_ch));
      chk("u5.in_ready",  32'(b5.in_ready),  er5);
`ifdef MUX_PARITY_EN
      chk("u5.out_par",   32'(b5.out_par),   32'(m5_par));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pack();
    for (int i = 0; i < 16; i++) b16.in_data[i*8 +: 8] = d16[i];
    for (int i = 0; i < 5; i++)  b5.in_data[i*8 +: 8]  = d5[i];
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rr_seq [6];
    rr_seq = '{0, 1, 15, 0, 1, 15};
    for (int i = 0; i < 16; i++) d16[i] = {4'(i), 4'(15 - i)};
    d16[5] = 8'hA5;
    for (int i = 0; i < 5; i++) d5[i] = 8'h50 + 8'(i);
    pack();
    rst16 = 1'b0; rst5 = 1'b0;
    b16.in_valid = '0; b16.mode = 1'b0; b16.sel = '0; b16.out_ready = 1'b1;
    b5.in_valid  = '0; b5.mode  = 1'b0; b5.sel  = '0; b5.out_ready  = 1'b1;

    // reset
    tick(); tick();
    chk("rst.out_valid", 32'(b16.out_valid), 32'd0);
    chk("rst.out_data",  32'(b16.out_data),  32'h00);
    chk("rst.out_ch",    32'(b16.out_ch),    32'd0);
    rst16 = 1'b0;
    rst16 = 1'b1; b16.mode = 1'b1; b16.in_valid = 16'h0001;
    #1;
    chk("rst.in_ready", 32'(b16.in_ready), 32'h0001);
    tick();

    // fixed select
    b16.mode = 1'b0; b16.sel = 4'd5; b16.in_valid = 16'hFFFF;
    #1;
    chk("fix.in_ready0", 32'(b16.in_ready), 32'h0020);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fix.out_data",  32'(b16.out_data),  32'hA5);
      chk("fix.out_ch",    32'(b16.out_ch),    32'd5);
      chk("fix.out_valid", 32'(b16.out_valid), 32'd1);
      chk("fix.in_ready",  32'(b16.in_ready),  32'h0020);
    end

    // round-robin wrap, starting after a fixed grant of channel 15
    b16.sel = 4'd15; b16.in_valid = 16'h8003;
    tick();
    b16.mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rr.out_ch", 32'(b16.out_ch), 32'(rr_seq[i]));
    end

    // backpressure then drain+reload in one cycle
    b16.out_ready = 1'b0; b16.in_valid = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp.in_ready",  32'(b16.in_ready),  32'h0000);
      chk("bp.out_data",  32'(b16.out_data),  32'hF0);
      chk("bp.out_valid", 32'(b16.out_valid), 32'd1);
    end
    b16.out_ready = 1'b1;
    tick();
    chk("bp.reload_valid", 32'(b16.out_valid), 32'd1);
    chk("bp.reload_ch",    32'(b16.out_ch),    32'd0);
    chk("bp.reload_data",  32'(b16.out_data),  32'h0F);
    b16.in_valid = '0;
    tick();
    chk("drain.out_valid", 32'(b16.out_valid), 32'd0);
    chk("drain.out_data",  32'(b16.out_data),  32'h0F);

    // fairness with every channel requesting
    b16.in_valid = 16'hFFFF;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("fair.out_ch", 32'(b16.out_ch), 32'((i + 1) % 16));
    end

    // parity data patterns
    b16.mode = 1'b0; b16.sel = 4'd3; d16[3] = 8'h07; pack();
    tick();
    chk("par.data07", 32'(b16.out_data), 32'h07);
`ifdef MUX_PARITY_EN
    chk("par.bit07", 32'(b16.out_par), 32'd1);
`endif
    d16[3] = 8'h03; pack();
    tick();
    chk("par.data03", 32'(b16.out_data), 32'h03);
`ifdef MUX_PARITY_EN
    chk("par.bit03", 32'(b16.out_par), 32'd0);
`endif
    b16.in_valid = '0;
    tick();

    // 5-channel boundary cases
    rst5 = 1'b1; b5.mode = 1'b0; b5.sel = 3'd2; b5.in_valid = 5'h1F;
    tick();
    chk("n5.out_ch",    32'(b5.out_ch),    32'd2);
    chk("n5.out_data",  32'(b5.out_data),  32'h52);
    b5.sel = 3'd6;
    #1;
    chk("n5.sel6_ready", 32'(b5.in_ready), 32'h00);
    tick();
    chk("n5.sel6_valid", 32'(b5.out_valid), 32'd0);
    chk("n5.sel6_data",  32'(b5.out_data),  32'h52);
    b5.sel = 3'd5;
    tick();
    chk("n5.sel5_valid", 32'(b5.out_valid), 32'd0);
    b5.mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("n5.rr_ch", 32'(b5.out_ch), 32'((3 + i) % 5));
    end
    rst5 = 1'b0;
    tick();
    chk("n5.mid_rst_valid", 32'(b5.out_valid), 32'd0);
    chk("n5.mid_rst_data",  32'(b5.out_data),  32'h00);
    rst5 = 1'b1;
    tick();
    chk("n5.post_rst_ch", 32'(b5.out_ch), 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
